audio_samp_queue: RTL

Circular stereo sample queue that sits directly upstream of each band FIR filter in the equalizer datapath. It stores the most recent DEPTH left/right sample pairs from the audio front end. After every new sample, once the window is full, it streams the whole window oldest-first, one pair per clock, while holding `sequencing` high. The filter consumes that stream: it restarts its coefficient address and accumulator on the rising edge of `sequencing` and multiplies one sample pair per cycle.

---
 rtl/eq_pkg.sv | 15 +
 rtl/dualport_ram_2k.sv | 25 ++
 rtl/audio_samp_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer datapath definitions.
//   DEPTH_HF / DEPTH_LF : window length (sample pairs) for the HF / LF band filters
//   SMPL_W              : audio sample width
//   state_t             : sample-queue readout state
package eq_pkg;
  localparam int DEPTH_HF = 1021;
  localparam int DEPTH_LF = 1021;
  localparam int SMPL_W   = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2
  } state_t;
endpackage

// File: rtl/dualport_ram_2k.sv
// Simple dual-port RAM, 2^AW x W. One write port and one synchronous read port.
// Read data appears the cycle after raddr_i/re_i and is held while re_i is low.
//   clk     : clock
//   we_i    : write enable, waddr_i/wdata_i : write address/data
//   re_i    : read enable,  raddr_i         : read address
//   rdata_o : read data, one cycle of latency
module dualport_ram_2k #(
  parameter int AW = 10,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/audio_samp_queue.sv
// Circular stereo sample queue feeding one band FIR filter. Keeps the newest
// DEPTH left/right pairs; after each new sample (once full) it streams the
// whole window oldest-first, one pair per clock, with sequencing held high.
//   clk, rst_n           : clock, asynchronous active-low reset
//   wrt_smpl             : one-cycle strobe, new pair on lft_smpl/rght_smpl
//   lft_smpl, rght_smpl  : incoming signed samples
//   sequencing           : high while a window sample is on the outputs
//   lft_out, rght_out    : streamed samples, zero when sequencing is low
module audio_samp_queue
  import eq_pkg::*;
#(
  parameter int DEPTH = DEPTH_HF,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  input  logic [SMPL_W-1:0] lft_smpl,
  input  logic [SMPL_W-1:0] rght_smpl,
  output logic              sequencing,
  output logic [SMPL_W-1:0] lft_out,
  output logic [SMPL_W-1:0] rght_out
);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_RD = AW'(DEPTH-1);

  state_t        state_q, state_d;
  logic [AW-1:0] new_ptr_q, new_ptr_d;
  logic [AW-1:0] old_ptr_q, old_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          pend_q, pend_d;
  logic          start;
  logic          rd_en;
  logic [2*SMPL_W-1:0] rdata;
  // [0]: RAM data valid this cycle, [1]: registered output valid
  logic [1:0]    vld_pipe_q;
  logic [SMPL_W-1:0] lft_q, rght_q;

  assign rd_en = (state_q == READ);

  always_comb begin
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_cnt_d  = rd_cnt_q;
    pend_d    = pend_q;
    start     = 1'b0;

    // Writes are accepted unconditionally; once full the oldest pair is dropped.
    if (wrt_smpl) begin
      new_ptr_d = new_ptr_q + 1'b1;
      if (cnt_q < DEPTH_C) cnt_d = cnt_q + 1'b1;
      else                 old_ptr_d = old_ptr_q + 1'b1;
    end

    unique case (state_q)
      FILL: if (wrt_smpl && cnt_d == DEPTH_C) start = 1'b1;
      // A pending readout lands here for one cycle first, giving the filter
      // the low gap it needs to see a fresh rising edge of sequencing.
      IDLE: if (wrt_smpl || pend_q) start = 1'b1;
      READ: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (wrt_smpl) pend_d = 1'b1;
        if (rd_cnt_q == LAST_RD) state_d = IDLE;
      end
      default: state_d = FILL;
    endcase

    // Window starts at the oldest pair after this cycle's write, so the last
    // streamed pair is the one just written.
    if (start) begin
      state_d  = READ;
      rd_ptr_d = old_ptr_d;
      rd_cnt_d = '0;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      new_ptr_q  <= '0;
      old_ptr_q  <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      pend_q     <= 1'b0;
      vld_pipe_q <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
    end else begin
      state_q    <= state_d;
      new_ptr_q  <= new_ptr_d;
      old_ptr_q  <= old_ptr_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      pend_q     <= pend_d;
      vld_pipe_q <= {vld_pipe_q[0], rd_en};
      lft_q      <= vld_pipe_q[0] ? rdata[2*SMPL_W-1:SMPL_W] : '0;
      rght_q     <= vld_pipe_q[0] ? rdata[SMPL_W-1:0]        : '0;
    end
  end

  dualport_ram_2k #(.AW(AW), .W(2*SMPL_W)) u_ram (
    .clk     (clk),
    .we_i    (wrt_smpl),
    .waddr_i (new_ptr_q),
    .wdata_i ({lft_smpl, rght_smpl}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign sequencing = vld_pipe_q[1];
  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
endmodule
